// File: rtl/estagio_operandos_ula.sv
// Operand-fetch stage: register file read, reg/imm mux for operand 2, one output register set for the ALU.
// Latency: 1 cycle from accept to out_valid; throughput 1/cycle while out_ready stays high.
// Backpressure: in_ready = !out_valid | out_ready; a stall holds every output bit-stable.
// Optional feature macro: OPERANDOS_BYPASS_EN (write-through forwarding of a same-cycle writeback).
module estagio_operandos_ula #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  // instruction from decode
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [DATA_W-1:0] imediato,
  input  logic              usa_imediato,
  input  logic [2:0]        op_in,
  input  logic [ADDR_W-1:0] rd_in,
  // operands to the ALU
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] entrada1,
  output logic [DATA_W-1:0] entrada2,
  output logic [2:0]        sinal_ula,
  output logic [ADDR_W-1:0] rd_out,
  // writeback from the ALU
  input  logic              escreve_reg,
  input  logic [ADDR_W-1:0] reg_escrita,
  input  logic [DATA_W-1:0] dado_escrita
);

  // Register 0 has no storage: it is the constant zero, so the array starts at index 1.
  // NUM_REGS must not exceed 2**ADDR_W, otherwise the upper registers are unreachable.
  logic [DATA_W-1:0] banco [1:NUM_REGS-1];

  logic [DATA_W-1:0] leitura1;
  logic [DATA_W-1:0] leitura2;
  logic [DATA_W-1:0] operando1;
  logic [DATA_W-1:0] operando2;
  logic              escrita_valida;
  logic              aceita;

  // Handshake: the output register can take a new instruction when empty or being drained.
  assign in_ready = !out_valid || out_ready;
  assign aceita   = in_valid && in_ready;

  // Writeback qualifier: only indices 1..NUM_REGS-1 are real registers.
  always_comb begin
    escrita_valida = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (reg_escrita == ADDR_W'(i)) escrita_valida = escreve_reg;
    end
  end

  // Source reads: index 0 and indices past the register count fall through to zero.
  always_comb begin
    leitura1 = '0;
    leitura2 = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rs1 == ADDR_W'(i)) leitura1 = banco[i];
      if (rs2 == ADDR_W'(i)) leitura2 = banco[i];
    end
  end

`ifdef OPERANDOS_BYPASS_EN
  // Forwarding: a writeback landing on the same edge as the accept is captured directly.
  always_comb begin
    operando1 = leitura1;
    operando2 = leitura2;
    if (escrita_valida && (reg_escrita == rs1)) operando1 = dado_escrita;
    if (escrita_valida && (reg_escrita == rs2)) operando2 = dado_escrita;
    if (usa_imediato) operando2 = imediato;
  end
`else
  // No forwarding: the pre-write register value is captured; the new one shows next accept.
  always_comb begin
    operando1 = leitura1;
    operando2 = usa_imediato ? imediato : leitura2;
  end
`endif

  // Register file write port; writes continue regardless of the output handshake.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < NUM_REGS; i++) banco[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (escrita_valida && (reg_escrita == ADDR_W'(i))) banco[i] <= dado_escrita;
      end
    end
  end

  // Output register: load on accept, clear valid on drain, otherwise hold every bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      entrada1  <= '0;
      entrada2  <= '0;
      sinal_ula <= 3'b000;
      rd_out    <= '0;
    end else if (aceita) begin
      out_valid <= 1'b1;
      entrada1  <= operando1;
      entrada2  <= operando2;
      sinal_ula <= op_in;
      rd_out    <= rd_in;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_estagio_operandos_ula.sv
// Bench for estagio_operandos_ula: scoreboard of expected operand sets, own register-file model.
// Inputs change on the falling edge; all observation happens 1 time unit after it.
// Honours OPERANDOS_BYPASS_EN the same way the design does.
module tb_estagio_operandos_ula;

  logic       clock;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] rs1;
  logic [2:0] rs2;
  logic [7:0] imediato;
  logic       usa_imediato;
  logic [2:0] op_in;
  logic [2:0] rd_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] entrada1;
  logic [7:0] entrada2;
  logic [2:0] sinal_ula;
  logic [2:0] rd_out;
  logic       escreve_reg;
  logic [2:0] reg_escrita;
  logic [7:0] dado_escrita;

  estagio_operandos_ula #(.DATA_W(8), .NUM_REGS(8), .ADDR_W(3)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .rs1          (rs1),
    .rs2          (rs2),
    .imediato     (imediato),
    .usa_imediato (usa_imediato),
    .op_in        (op_in),
    .rd_in        (rd_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .entrada1     (entrada1),
    .entrada2     (entrada2),
    .sinal_ula    (sinal_ula),
    .rd_out       (rd_out),
    .escreve_reg  (escreve_reg),
    .reg_escrita  (reg_escrita),
    .dado_escrita (dado_escrita)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic [7:0] e1;
    logic [7:0] e2;
    logic [2:0] op;
    logic [2:0] rd;
  } esperado_t;

  esperado_t  fila[$];
  logic [7:0] m_regs [8];
  logic       m_ov;
  int         n_cmp;
  int         n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] le_m(input logic [2:0] idx);
    logic [7:0] v;
    v = (idx == 3'd0) ? 8'h00 : m_regs[idx];
`ifdef OPERANDOS_BYPASS_EN
    if (escreve_reg && reg_escrita != 3'd0 && reg_escrita == idx) v = dado_escrita;
`endif
    return v;
  endfunction

  // One cycle: observe just after the falling edge (inputs already set), then advance.
  task automatic tick();
    esperado_t e;
    logic      acc;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_ov || out_ready)});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    if (m_ov) begin
      if (fila.size() == 0) begin
        chk("fila_vazia", 32'd1, 32'd0);
      end else begin
        e = fila[0];
        chk("entrada1", {24'd0, entrada1}, {24'd0, e.e1});
        chk("entrada2", {24'd0, entrada2}, {24'd0, e.e2});
        chk("sinal_ula", {29'd0, sinal_ula}, {29'd0, e.op});
        chk("rd_out", {29'd0, rd_out}, {29'd0, e.rd});
        if (out_ready) void'(fila.pop_front());
      end
    end
    acc = in_valid && (!m_ov || out_ready);
    if (acc) begin
      e.e1 = le_m(rs1);
      e.e2 = usa_imediato ? imediato : le_m(rs2);
      e.op = op_in;
      e.rd = rd_in;
      fila.push_back(e);
    end
    m_ov = acc ? 1'b1 : (out_ready ? 1'b0 : m_ov);
    if (escreve_reg && reg_escrita != 3'd0) m_regs[reg_escrita] = dado_escrita;
    @(negedge clock);
  endtask

  task automatic ocioso();
    in_valid     = 1'b0;
    escreve_reg  = 1'b0;
    usa_imediato = 1'b0;
    out_ready    = 1'b1;
  endtask

  task automatic instr(input logic [2:0] a, input logic [2:0] b, input logic ui,
                       input logic [7:0] imm, input logic [2:0] op, input logic [2:0] d);
    in_valid     = 1'b1;
    rs1          = a;
    rs2          = b;
    usa_imediato = ui;
    imediato     = imm;
    op_in        = op;
    rd_in        = d;
  endtask

  task automatic escreve(input logic [2:0] r, input logic [7:0] d);
    escreve_reg  = 1'b1;
    reg_escrita  = r;
    dado_escrita = d;
  endtask

  task automatic limpa_modelo();
    fila.delete();
    m_ov = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
  endtask

  // Reset asserted mid-cycle: outputs must drop immediately, model restarts empty.
  task automatic reset_assincrono();
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_entrada1", {24'd0, entrada1}, 32'd0);
    chk("rst_entrada2", {24'd0, entrada2}, 32'd0);
    chk("rst_sinal_ula", {29'd0, sinal_ula}, 32'd0);
    chk("rst_rd_out", {29'd0, rd_out}, 32'd0);
    limpa_modelo();
    ocioso();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    rs1 = 3'd0; rs2 = 3'd0; imediato = 8'h00; op_in = 3'd0; rd_in = 3'd0;
    reg_escrita = 3'd0; dado_escrita = 8'h00;
    ocioso();
    limpa_modelo();
    @(negedge clock);
    @(negedge clock);
    chk("ini_out_valid", {31'd0, out_valid}, 32'd0);
    chk("ini_entrada1", {24'd0, entrada1}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // R3 = 0x5A, then add R3, R0
    escreve(3'd3, 8'h5A); tick(); ocioso();
    instr(3'd3, 3'd0, 1'b0, 8'h00, 3'b010, 3'd1); tick(); ocioso();
    tick();
    // write to R0 is ignored
    escreve(3'd0, 8'hFF); tick(); ocioso();
    instr(3'd0, 3'd0, 1'b0, 8'h00, 3'b000, 3'd2); tick(); ocioso();
    tick();
    // immediate overrides R[rs2]
    escreve(3'd2, 8'h21); tick();
    escreve(3'd6, 8'hC3); tick(); ocioso();
    instr(3'd2, 3'd6, 1'b1, 8'h80, 3'b001, 3'd7); tick(); ocioso();
    tick();
    // stall for 3 cycles with a waiting instruction; a writeback to the held source meanwhile
    escreve(3'd5, 8'h44); tick(); ocioso();
    instr(3'd5, 3'd3, 1'b0, 8'h00, 3'b011, 3'd4); tick();
    instr(3'd6, 3'd2, 1'b0, 8'h00, 3'b100, 3'd5);
    out_ready = 1'b0;
    escreve(3'd5, 8'h99); tick(); escreve_reg = 1'b0;
    tick(); tick();
    out_ready = 1'b1; tick();
    instr(3'd5, 3'd1, 1'b0, 8'h00, 3'b010, 3'd6); tick();
    instr(3'd1, 3'd5, 1'b1, 8'h07, 3'b000, 3'd3); tick();
    ocioso(); tick(); tick();
    // accept racing a writeback to the source register
    escreve(3'd4, 8'h11); tick(); ocioso();
    instr(3'd4, 3'd4, 1'b0, 8'h00, 3'b010, 3'd2);
    escreve(3'd4, 8'h33); tick(); ocioso();
    instr(3'd4, 3'd0, 1'b0, 8'h00, 3'b010, 3'd2); tick(); ocioso();
    tick();

    // random traffic with random backpressure
    for (int c = 0; c < 300; c++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      rs1          = 3'($urandom_range(0, 7));
      rs2          = 3'($urandom_range(0, 7));
      usa_imediato = ($urandom_range(0, 3) == 0);
      imediato     = 8'($urandom);
      op_in        = 3'($urandom_range(0, 4));
      rd_in        = 3'($urandom_range(0, 7));
      escreve_reg  = ($urandom_range(0, 1) == 1);
      reg_escrita  = 3'($urandom_range(0, 7));
      dado_escrita = 8'($urandom);
      out_ready    = ($urandom_range(0, 2) != 0);
      tick();
    end

    // mid-stream reset, then every register must read back zero
    instr(3'd1, 3'd2, 1'b0, 8'h00, 3'b001, 3'd1);
    out_ready = 1'b0;
    reset_assincrono();
    for (int r = 0; r < 8; r++) begin
      instr(3'(r), 3'(7 - r), 1'b0, 8'h00, 3'b000, 3'(r));
      tick();
    end
    ocioso();
    tick(); tick();
    chk("fila_drenada", fila.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
